// File: rtl/store_aligner_pkg.sv
// Shared MEM-stage definitions used by both the load read aligner and the store aligner.
// Holds the access-size encodings and the packed store-buffer entry.
package store_aligner_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic MEM_SIGNED   = 1'b0;
    localparam logic MEM_UNSIGNED = 1'b1;

    localparam int XLEN      = 32;
    localparam int NUM_LANES = XLEN / 8;

    typedef struct packed {
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      data;
        logic [NUM_LANES-1:0] web;
    } store_entry_t;

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_aligner_if.sv
// Pipeline-side store request and data-memory-side write bus of the store aligner.
// slave = the aligner, master = whoever drives requests and the memory ready.
interface store_aligner_if;
    import store_aligner_pkg::*;

    logic                 st_valid;
    logic                 st_ready;
    logic [4:0]           mem_op;
    logic [XLEN-1:0]      st_addr;
    logic [XLEN-1:0]      st_data;
    logic                 misalign;
    logic                 buf_empty;
    logic                 dm_valid;
    logic                 dm_ready;
    logic [XLEN-1:0]      dm_addr;
    logic [XLEN-1:0]      dm_wdata;
    logic [NUM_LANES-1:0] dm_web;

    modport slave (
        input  st_valid, mem_op, st_addr, st_data, dm_ready,
        output st_ready, misalign, buf_empty, dm_valid, dm_addr, dm_wdata, dm_web
    );

    modport master (
        output st_valid, mem_op, st_addr, st_data, dm_ready,
        input  st_ready, misalign, buf_empty, dm_valid, dm_addr, dm_wdata, dm_web
    );

endinterface

// File: rtl/store_aligner_lane_gen.sv
// Combinational byte-lane steering for stores: replicates rs2 data into every lane
// and enables only the lanes the access actually touches.
module store_lane_gen
    import store_aligner_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic [XLEN-1:0]      data,
    output logic [XLEN-1:0]      wdata,
    output logic [NUM_LANES-1:0] web,
    output logic                 misaligned
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] IDX = 2'(i);

        // Halfword pairs share the low 16 bits; lanes 2/3 sit in the upper half.
        assign wdata[8*i +: 8] = (size == MEM_BYTE) ? data[7:0] :
                                 (size == MEM_HALF) ? data[8*(i%2) +: 8] :
                                                      data[8*i +: 8];

        assign web[i] = ((size == MEM_BYTE) && (addr_lo == IDX))
                     || ((size == MEM_HALF) && (addr_lo[1] == IDX[1]))
                     ||  (size == MEM_WORD);
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = addr_lo[0];
            MEM_WORD: misaligned = |addr_lo;
            default:  misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_aligner.sv
// MEM-stage store path: lane-steers each store and parks aligned ones in a small FIFO
// that drains to data memory, dropping misaligned stores with a one-cycle flag.
module store_aligner
    import store_aligner_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    store_aligner_if.slave   bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    store_entry_t         mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 misalign_q;

    logic [XLEN-1:0]      lane_wdata;
    logic [NUM_LANES-1:0] lane_web;
    logic                 lane_mis;
    store_entry_t         new_entry;
    store_entry_t         head;

    logic full, empty, accept, enq, deq;

    logic unused;
    assign unused = ^bus.mem_op[4:2];

    store_lane_gen u_lane_gen (
        .size       (bus.mem_op[1:0]),
        .addr_lo    (bus.st_addr[1:0]),
        .data       (bus.st_data),
        .wdata      (lane_wdata),
        .web        (lane_web),
        .misaligned (lane_mis)
    );

    assign new_entry = '{addr: word_addr(bus.st_addr), data: lane_wdata, web: lane_web};

    // st_ready depends only on registered occupancy, never on dm_ready.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign accept = bus.st_valid && !full;
    assign enq    = accept && !lane_mis;
    assign deq    = !empty && bus.dm_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            misalign_q <= accept && lane_mis;
            if (enq) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            if (enq && !deq)      count <= count + CW'(1);
            else if (deq && !enq) count <= count - CW'(1);
        end
    end

    // Head is read straight from storage, so it holds while the memory stalls.
    assign head          = mem[rd_ptr];
    assign bus.st_ready  = !full;
    assign bus.buf_empty = empty;
    assign bus.dm_valid  = !empty;
    assign bus.dm_addr   = head.addr;
    assign bus.dm_wdata  = head.data;
    assign bus.dm_web    = head.web;
    assign bus.misalign  = misalign_q;

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-side counterpart of the load read-alignment path in the MEM stage. Takes a store request (mem_op, byte address, rs2 data) from the pipeline and replicates the data into the addressed byte lanes. Generates a 4-bit byte-write strobe and flags misaligned accesses. Aligned stores are queued in a small FIFO store buffer that drains to data memory over a valid/ready handshake, so the pipeline does not stall on memory back-pressure until the buffer fills.

## Interface
- DEPTH, 2, store-buffer entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- st_valid  input  1  pipeline presents a store this cycle
- st_ready  output  1  buffer can accept; equals !full
- mem_op  input  5  [1:0] size (MEM_BYTE/MEM_HALF/MEM_WORD), [2] signedness (ignored for stores), [4:3] unused here
- st_addr  input  32  byte address
- st_data  input  32  rs2 value, data in low bits
- misalign  output  1  one-cycle pulse, registered: an accepted store was misaligned and dropped
- buf_empty  output  1  no pending stores (load-hazard check)
- dm_valid  output  1  head entry valid toward data memory
- dm_ready  input  1  memory accepts the head entry
- dm_addr  output  32  word address, {st_addr[31:2], 2'b00}
- dm_wdata  output  32  lane-replicated data
- dm_web  output  4  byte-write strobe, bit i = byte lane i

## Operation
- Accept when st_valid && st_ready.
- Lane mapping by size:
  - MEM_BYTE: wdata = {4{st_data[7:0]}}, web = 4'b0001 << addr[1:0].
  - MEM_HALF: wdata = {2{st_data[15:0]}}, web = 4'b0011 << {addr[1],1'b0}.
  - MEM_WORD: wdata = st_data, web = 4'b1111.
  - Size 2'b11 is treated as misaligned.
- Misaligned stores are accepted (st_ready honoured) but not enqueued, and misalign pulses the next cycle:
  - MEM_HALF with addr[0]=1
  - MEM_WORD with addr[1:0]≠0
  - size 2'b11
- The FIFO holds {word addr, wdata, web}. Head entry is driven combinationally from storage.
- Occupancy count is 0..DEPTH. full = (count==DEPTH), buf_empty = (count==0).
- Pointers wrap modulo DEPTH.
- Dequeue when dm_valid && dm_ready.
- Same-cycle enqueue and dequeue: count unchanged, both pointers advance.
  - When full, st_ready=0 even if a dequeue occurs that cycle. There is no full-bypass, so st_ready has no combinational path from dm_ready.
- The store buffer has no data-forwarding path to loads; buf_empty is the only hazard indication.
- While dm_valid=1 and dm_ready=0, all dm_* outputs hold stable.

## Timing
- Reset values (async assert, sync deassert handled upstream):
  - count=0, pointers=0, misalign=0
  - dm_valid=0, buf_empty=1, st_ready=1
  - dm_addr/dm_wdata/dm_web=0
- Enqueue-to-dm_valid latency: 1 cycle. A store accepted at edge N is visible on dm_* after edge N; with an empty buffer, dm_valid=1 in cycle N+1.
- misalign is high for exactly one cycle after the accepting edge; back-to-back misaligned stores give consecutive pulses.
- Reset asserted mid-drain discards all entries immediately; dm_valid drops asynchronously.
- Throughput: one store per cycle sustained when dm_ready is held high.

## Structure
- The shared pipeline package holds:
  - MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10
  - MEM_SIGNED=1'b0, MEM_UNSIGNED=1'b1
  - a store-entry packed struct {addr[31:0], data[31:0], web[3:0]}
- The read aligner and this block both import the package.
- One sub-module: store_lane_gen, combinational, mem_op[1:0] + addr[1:0] + data → wdata, web, misaligned. It is instantiated ahead of the FIFO.
- FIFO storage and control stay in store_aligner.

## Test plan
- Byte store, addr=0x1003, data=0x000000A5, dm_ready=1 → next cycle dm_addr=0x1000, dm_wdata=0xA5A5A5A5, dm_web=4'b1000, misalign=0.
- Half store, addr=0x2002, data=0x0000BEEF → dm_wdata=0xBEEFBEEF, dm_web=4'b1100. Half store at addr=0x2001 → misalign pulses 1 cycle, nothing enqueued, buf_empty stays 1.
- dm_ready=0, issue 3 word stores (0x10,0x14,0x18) → first two accepted, st_ready=0 on the third. Raise dm_ready → entries drain in order 0x10,0x14, then the third is accepted the cycle after full clears.
- Full buffer, simultaneous st_valid and dm_ready → st_ready=0 that cycle, count goes DEPTH→DEPTH-1, no data loss or duplication.
- Assert rst with 2 entries pending → dm_valid=0, buf_empty=1 immediately. After release, a new word store 0xDEADBEEF@0x40 appears with web=4'b1111.
- Continuous random aligned stores with dm_ready toggling randomly → scoreboard checks every accepted store appears exactly once, in order, and dm_* stay stable while stalled.
